// File: rtl/ifu_fetch_pkg.sv
// Shared fetch/decode definitions: FSM states, response codes and the ifu_data layout.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_t;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  // Decode unpacks the same layout: inst in [63:32], pc in [31:0].
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ifu_data_t;

  function automatic ifu_data_t ifu_pack(input logic [31:0] inst, input logic [31:0] pc);
    ifu_data_t d;
    d.inst = inst;
    d.pc   = pc;
    return d;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-side buses: split address/data instruction read channel and the decode handshake.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic        ifu_valid;
  ifu_data_t   ifu_data;
  logic        idu_ready;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output ifu_valid, ifu_data, araddr, arvalid, rready,
    input  idu_ready, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  ifu_valid, ifu_data, araddr, arvalid, rready,
    output idu_ready, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: one read per retired instruction, {inst, pc} handed to decode; zero-wait
// memory gives ifu_valid 3 cycles after launch. Stalls hold state; updates while busy are parked.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_update_valid,
  input  logic [31:0] pc_next,
  output logic        access_fault,
  ifu_fetch_if.master bus
);

  ifu_state_t  r_state;
  ifu_state_t  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic        r_boot;
  logic        r_pend;
  logic        r_fault;
  ifu_data_t   r_data;

  logic w_launch;
  logic w_r_ok;
  logic w_r_err;
  logic w_arvalid;
  logic w_rready;
  logic w_ifu_valid;

  assign w_launch = r_boot | r_pend | pc_update_valid;
  assign w_r_ok   = bus.rvalid && (bus.rresp == RESP_OKAY);
  assign w_r_err  = bus.rvalid && (bus.rresp != RESP_OKAY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_ifu_valid = 1'b0;
    case (r_state)
      S_IDLE: if (w_launch) w_state_nxt = S_AR;
      S_AR: begin
        w_arvalid = 1'b1;
        if (bus.arready) w_state_nxt = S_R;
      end
      S_R: begin
        w_rready = 1'b1;
        if (w_r_ok) w_state_nxt = S_OUT;
        else if (w_r_err) w_state_nxt = S_IDLE;
      end
      S_OUT: begin
        w_ifu_valid = 1'b1;
        if (bus.idu_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // PC is only retargeted when a fetch launches, so araddr stays put for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_pend_pc <= '0;
      r_boot    <= 1'b1;
      r_pend    <= 1'b0;
      r_fault   <= 1'b0;
      r_data    <= '0;
    end else begin
      r_fault <= (r_state == S_R) && w_r_err;
      if (r_state == S_IDLE) begin
        if (w_launch) begin
          r_boot <= 1'b0;
          r_pend <= 1'b0;
          if (pc_update_valid) r_pc <= pc_next;
          else if (r_pend) r_pc <= r_pend_pc;
        end
      end else if (pc_update_valid) begin
        r_pend    <= 1'b1;
        r_pend_pc <= pc_next;
      end
      if ((r_state == S_R) && w_r_ok) r_data <= ifu_pack(bus.rdata, r_pc);
    end
  end

  assign bus.arvalid   = w_arvalid;
  assign bus.araddr    = r_pc;
  assign bus.rready    = w_rready;
  assign bus.ifu_valid = w_ifu_valid;
  assign bus.ifu_data  = r_data;
  assign access_fault  = r_fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: directed fetches, a scripted memory responder and a negedge monitor.
`timescale 1ns/1ps
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_update_valid = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic        access_fault;

  ifu_fetch_if bus();

  ifu_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .pc_update_valid (pc_update_valid),
    .pc_next         (pc_next),
    .access_fault    (access_fault),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ar_wait;
    int          r_wait;
    logic [1:0]  resp;
    logic [31:0] data;
  } mem_rsp_t;

  mem_rsp_t    mem_q[$];
  logic [31:0] exp_ar_q[$];
  logic [63:0] exp_data_q[$];
  int          exp_fault = 0;
  int          n_pass = 0;
  int          n_total = 0;
  bit          ar_hs = 1'b0;
  bit          r_hs = 1'b0;
  bit          mem_phase = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Queue one memory response and the address/result it must produce.
  task automatic plan(input int aw, input int rw, input logic [1:0] resp, input logic [31:0] addr,
                      input logic [31:0] data, input bit completes, input logic [63:0] exp_data);
    mem_rsp_t m;
    m.ar_wait = aw;
    m.r_wait  = rw;
    m.resp    = resp;
    m.data    = data;
    mem_q.push_back(m);
    exp_ar_q.push_back(addr);
    if (resp != RESP_OKAY) exp_fault++;
    else if (completes) exp_data_q.push_back(exp_data);
  endtask

  task automatic upd(input logic [31:0] pc);
    @(posedge clk); #1;
    pc_update_valid = 1'b1;
    pc_next = pc;
    @(posedge clk); #1;
    pc_update_valid = 1'b0;
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return bus.ifu_valid;
      1:       return bus.rready;
      2:       return access_fault;
      default: return exp_data_q.size() == 0;
    endcase
  endfunction

  task automatic wait_on(input int which, input int lim, input string name);
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (cond(which)) return;
    end
    n_total++;
    $display("FAIL %s: no event within %0d cycles", name, lim);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"},   64'(bus.arvalid),   64'd0);
    chk({tag, "_rready"},    64'(bus.rready),    64'd0);
    chk({tag, "_ifu_valid"}, 64'(bus.ifu_valid), 64'd0);
    chk({tag, "_ifu_data"},  64'(bus.ifu_data),  64'd0);
    chk({tag, "_fault"},     64'(access_fault),  64'd0);
  endtask

  // Memory responder: each accepted address consumes one scripted response.
  initial begin
    mem_rsp_t cur;
    bit       have;
    int       cnt;
    have = 1'b0;
    cnt = 0;
    cur.ar_wait = 0; cur.r_wait = 0; cur.resp = RESP_OKAY; cur.data = 32'h0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        mem_phase = 1'b0; have = 1'b0; cnt = 0;
        bus.arready = 1'b0; bus.rvalid = 1'b0;
      end else begin
        if (mem_phase && r_hs) begin
          bus.rvalid = 1'b0; mem_phase = 1'b0; have = 1'b0;
        end
        if (!mem_phase && ar_hs) begin
          bus.arready = 1'b0; mem_phase = 1'b1; cnt = 0;
        end else if (!mem_phase && bus.arvalid) begin
          if (!have) begin
            chk("mem_rsp_queued", 64'(mem_q.size() != 0), 64'd1);
            if (mem_q.size() != 0) cur = mem_q.pop_front();
            have = 1'b1; cnt = 0;
          end
          if (cnt >= cur.ar_wait) bus.arready = 1'b1;
          else cnt++;
        end
        if (mem_phase && !bus.rvalid) begin
          if (cnt >= cur.r_wait) begin
            bus.rvalid = 1'b1; bus.rdata = cur.data; bus.rresp = cur.resp;
          end else cnt++;
        end
      end
    end
  end

  // Monitor: protocol stability plus scoreboard pops on every handshake.
  initial begin
    logic        p_arv, p_arr, p_iv, p_ir, p_fault, p_rst;
    logic [31:0] p_addr;
    logic [63:0] p_data;
    p_arv = 0; p_arr = 0; p_iv = 0; p_ir = 0; p_fault = 0; p_rst = 1; p_addr = 0; p_data = 0;
    forever begin
      @(negedge clk);
      ar_hs = bus.arvalid && bus.arready && !rst;
      r_hs  = bus.rvalid && bus.rready && !rst;
      if (!rst && !p_rst) begin
        if (p_arv && !p_arr) begin
          chk("arvalid_held", 64'(bus.arvalid), 64'd1);
          chk("araddr_stable", 64'(bus.araddr), 64'(p_addr));
        end
        if (p_iv && !p_ir) begin
          chk("ifu_valid_held", 64'(bus.ifu_valid), 64'd1);
          chk("ifu_data_stable", 64'(bus.ifu_data), p_data);
        end
        if (p_iv && p_ir) chk("ifu_valid_drop", 64'(bus.ifu_valid), 64'd0);
        chk("rready_only_in_R", 64'(bus.rready), 64'(mem_phase));
        if (bus.arvalid && bus.arready) begin
          chk("ar_expected", 64'(exp_ar_q.size() != 0), 64'd1);
          if (exp_ar_q.size() != 0) chk("araddr", 64'(bus.araddr), 64'(exp_ar_q.pop_front()));
        end
        if (bus.ifu_valid && bus.idu_ready) begin
          chk("xfer_expected", 64'(exp_data_q.size() != 0), 64'd1);
          if (exp_data_q.size() != 0) chk("ifu_data", 64'(bus.ifu_data), exp_data_q.pop_front());
        end
        if (access_fault) begin
          chk("fault_expected", 64'(exp_fault > 0), 64'd1);
          if (exp_fault > 0) exp_fault--;
          chk("fault_width", 64'(p_fault), 64'd0);
        end
      end
      p_arv = bus.arvalid; p_arr = bus.arready; p_addr = bus.araddr;
      p_iv = bus.ifu_valid; p_ir = bus.idu_ready; p_data = bus.ifu_data;
      p_fault = access_fault; p_rst = rst;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.idu_ready = 1'b1;

    // Boot fetch, zero-wait memory
    plan(0, 0, RESP_OKAY, RPC, 32'h0000_0413, 1'b1, 64'h0000_0413_8000_0000);
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("c0_arvalid", 64'(bus.arvalid), 64'd0);
    @(negedge clk);
    chk("c1_arvalid", 64'(bus.arvalid), 64'd1);
    chk("c1_araddr", 64'(bus.araddr), 64'(RPC));
    @(negedge clk);
    chk("c2_rready", 64'(bus.rready), 64'd1);
    @(negedge clk);
    chk("c3_ifu_valid", 64'(bus.ifu_valid), 64'd1);
    chk("c3_ifu_data", 64'(bus.ifu_data), 64'h0000_0413_8000_0000);

    // Decode back-pressure for 5 cycles
    @(posedge clk); #1 bus.idu_ready = 1'b0;
    plan(0, 0, RESP_OKAY, 32'h8000_0004, 32'h00a0_0093, 1'b1, 64'h00a0_0093_8000_0004);
    upd(32'h8000_0004);
    wait_on(0, 20, "stall_ifu_valid");
    repeat (5) @(negedge clk);
    chk("stall_no_xfer", 64'(exp_data_q.size()), 64'd1);
    @(posedge clk); #1 bus.idu_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 bus.idu_ready = 1'b0;
    @(negedge clk);
    chk("stall_valid_fell", 64'(bus.ifu_valid), 64'd0);
    chk("stall_one_xfer", 64'(exp_data_q.size()), 64'd0);

    // Updates during S_R then S_OUT: the latest one is fetched
    plan(0, 2, RESP_OKAY, 32'h8000_0008, 32'h1111_1111, 1'b1, 64'h1111_1111_8000_0008);
    upd(32'h8000_0008);
    wait_on(1, 20, "pend_rready");
    upd(32'h8000_0010);
    wait_on(0, 20, "pend_ifu_valid");
    plan(0, 0, RESP_OKAY, 32'h8000_0020, 32'h2222_2222, 1'b1, 64'h2222_2222_8000_0020);
    upd(32'h8000_0020);
    bus.idu_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pend_idle_arvalid", 64'(bus.arvalid), 64'd0);
    @(negedge clk);
    chk("pend_arvalid", 64'(bus.arvalid), 64'd1);
    chk("pend_araddr", 64'(bus.araddr), 64'h8000_0020);
    wait_on(3, 20, "pend_xfer");

    // Error response, then recovery
    plan(0, 0, 2'b10, 32'h8000_0030, 32'hdead_beef, 1'b0, 64'h0);
    upd(32'h8000_0030);
    wait_on(2, 20, "fault_pulse");
    @(negedge clk);
    chk("fault_low_after", 64'(access_fault), 64'd0);
    chk("fault_no_valid", 64'(bus.ifu_valid), 64'd0);
    plan(0, 0, RESP_OKAY, 32'h8000_0100, 32'h0010_0093, 1'b1, 64'h0010_0093_8000_0100);
    upd(32'h8000_0100);
    wait_on(3, 20, "fault_recover_xfer");

    // Memory stalls on both channels
    plan(4, 3, RESP_OKAY, 32'h8000_0200, 32'h4444_4444, 1'b1, 64'h4444_4444_8000_0200);
    upd(32'h8000_0200);
    wait_on(3, 40, "stall_mem_xfer");

    // Reset while in S_R with an update parked
    plan(0, 10, RESP_OKAY, 32'h8000_0300, 32'h6666_6666, 1'b0, 64'h0);
    upd(32'h8000_0300);
    wait_on(1, 20, "rst_rready");
    upd(32'h8000_0400);
    rst = 1'b1;
    @(negedge clk);
    plan(0, 0, RESP_OKAY, RPC, 32'h0000_0513, 1'b1, 64'h0000_0513_8000_0000);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(negedge clk);
    chk("midrst_arvalid", 64'(bus.arvalid), 64'd1);
    chk("midrst_araddr", 64'(bus.araddr), 64'(RPC));
    wait_on(3, 20, "midrst_xfer");

    repeat (3) @(negedge clk);
    chk("end_ar_q", 64'(exp_ar_q.size()), 64'd0);
    chk("end_data_q", 64'(exp_data_q.size()), 64'd0);
    chk("end_mem_q", 64'(mem_q.size()), 64'd0);
    chk("end_fault", 64'(exp_fault), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
